// File: rtl/tri_wave_meas.sv
// Triangle-wave receive analyser: hysteresis turning-point detection on an
// 8-bit sample stream, reporting period, rise time, extrema, lock and loss of signal.
module tri_wave_meas #(
    parameter int DT_W    = 8,
    parameter int CNT_W   = 32,
    parameter int HYST    = 4,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [DT_W-1:0]  sample,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] rise_time,
    output logic [DT_W-1:0]  vmax,
    output logic [DT_W-1:0]  vmin,
    output logic             locked,
    output logic             no_signal
);
    typedef enum logic [1:0] {SEEK, RISE, FALL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [DT_W:0]    HYST_C    = (DT_W+1)'(HYST);

    state_t           state_q, state_d;
    logic [DT_W-1:0]  cur_max_q, cur_max_d, cur_min_q, cur_min_d, tr_val_q, tr_val_d;
    logic             first_q, first_d, have_peak_q, have_peak_d, have_trough_q, have_trough_d;
    logic [CNT_W-1:0] cnt_pk_q, cnt_pk_d, cnt_tr_q, cnt_tr_d, cnt_idle_q, cnt_idle_d;
    logic [CNT_W-1:0] prev_period_q, prev_period_d;
    logic             meas_valid_q, meas_valid_d, locked_q, locked_d, no_signal_q, no_signal_d;
    logic [CNT_W-1:0] period_q, period_d, rise_time_q, rise_time_d;
    logic [DT_W-1:0]  vmax_q, vmax_d, vmin_q, vmin_d;

    logic             up_hit, dn_hit, peak_ev, trough_ev;
    logic [CNT_W-1:0] period_new, rise_new, period_diff, idle_inc;

    // Thresholds in DT_W+1 bits so cur_min+HYST and sample+HYST never wrap.
    assign up_hit = {1'b0, sample} >= ({1'b0, cur_min_q} + HYST_C);
    assign dn_hit = ({1'b0, sample} + HYST_C) <= {1'b0, cur_max_q};

    // A saturated counter reports its saturated value rather than wrapping.
    assign period_new  = (cnt_pk_q == CNT_MAX) ? CNT_MAX : cnt_pk_q + CNT_ONE;
    assign rise_new    = (cnt_tr_q == CNT_MAX) ? CNT_MAX : cnt_tr_q + CNT_ONE;
    assign period_diff = (period_new >= prev_period_q) ? period_new - prev_period_q
                                                       : prev_period_q - period_new;
    assign idle_inc    = cnt_idle_q + CNT_ONE;

    always_comb begin
        state_d       = state_q;
        cur_max_d     = cur_max_q;
        cur_min_d     = cur_min_q;
        tr_val_d      = tr_val_q;
        first_d       = first_q;
        have_peak_d   = have_peak_q;
        have_trough_d = have_trough_q;
        prev_period_d = prev_period_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        no_signal_d   = no_signal_q;
        period_d      = period_q;
        rise_time_d   = rise_time_q;
        vmax_d        = vmax_q;
        vmin_d        = vmin_q;
        peak_ev       = 1'b0;
        trough_ev     = 1'b0;

        if (sample_valid) begin
            case (state_q)
                SEEK: begin
                    if (first_q) begin
                        cur_max_d = sample;
                        cur_min_d = sample;
                        first_d   = 1'b0;
                    end else if (up_hit) begin
                        state_d   = RISE;
                        cur_max_d = sample;
                    end else if (dn_hit) begin
                        state_d   = FALL;
                        cur_min_d = sample;
                    end else begin
                        if (sample > cur_max_q) cur_max_d = sample;
                        if (sample < cur_min_q) cur_min_d = sample;
                    end
                end
                RISE: begin
                    if (dn_hit) begin
                        peak_ev   = 1'b1;
                        state_d   = FALL;
                        cur_min_d = sample;
                    end else if (sample > cur_max_q) begin
                        cur_max_d = sample;
                    end
                end
                FALL: begin
                    if (up_hit) begin
                        trough_ev = 1'b1;
                        state_d   = RISE;
                        cur_max_d = sample;
                        tr_val_d  = cur_min_q;
                    end else if (sample < cur_min_q) begin
                        cur_min_d = sample;
                    end
                end
                default: state_d = SEEK;
            endcase
        end

        cnt_pk_d = peak_ev   ? '0 : (cnt_pk_q == CNT_MAX ? CNT_MAX : cnt_pk_q + CNT_ONE);
        cnt_tr_d = trough_ev ? '0 : (cnt_tr_q == CNT_MAX ? CNT_MAX : cnt_tr_q + CNT_ONE);

        if (peak_ev) begin
            have_peak_d = 1'b1;
            no_signal_d = 1'b0;
            if (have_peak_q && have_trough_q) begin
                meas_valid_d  = 1'b1;
                period_d      = period_new;
                rise_time_d   = rise_new;
                vmax_d        = cur_max_q;
                vmin_d        = tr_val_q;
                if (prev_period_q != '0) locked_d = (period_diff <= (prev_period_q >> 3));
                prev_period_d = period_new;
            end
        end
        if (trough_ev) begin
            have_trough_d = 1'b1;
            no_signal_d   = 1'b0;
        end

        // Timeout fires once, on the edge the idle counter reaches TIMEOUT, so the
        // re-armed FSM is free to acquire again while the counter sits saturated.
        cnt_idle_d = cnt_idle_q;
        if (peak_ev || trough_ev) begin
            cnt_idle_d = '0;
        end else if (cnt_idle_q != TIMEOUT_C) begin
            cnt_idle_d = idle_inc;
            if (idle_inc == TIMEOUT_C) begin
                no_signal_d   = 1'b1;
                locked_d      = 1'b0;
                state_d       = SEEK;
                first_d       = 1'b1;
                have_peak_d   = 1'b0;
                have_trough_d = 1'b0;
                prev_period_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEEK;
            cur_max_q     <= '0;
            cur_min_q     <= '0;
            tr_val_q      <= '0;
            first_q       <= 1'b1;
            have_peak_q   <= 1'b0;
            have_trough_q <= 1'b0;
            cnt_pk_q      <= '0;
            cnt_tr_q      <= '0;
            cnt_idle_q    <= '0;
            prev_period_q <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            no_signal_q   <= 1'b1;
            period_q      <= '0;
            rise_time_q   <= '0;
            vmax_q        <= '0;
            vmin_q        <= '0;
        end else begin
            state_q       <= state_d;
            cur_max_q     <= cur_max_d;
            cur_min_q     <= cur_min_d;
            tr_val_q      <= tr_val_d;
            first_q       <= first_d;
            have_peak_q   <= have_peak_d;
            have_trough_q <= have_trough_d;
            cnt_pk_q      <= cnt_pk_d;
            cnt_tr_q      <= cnt_tr_d;
            cnt_idle_q    <= cnt_idle_d;
            prev_period_q <= prev_period_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            no_signal_q   <= no_signal_d;
            period_q      <= period_d;
            rise_time_q   <= rise_time_d;
            vmax_q        <= vmax_d;
            vmin_q        <= vmin_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period     = period_q;
    assign rise_time  = rise_time_q;
    assign vmax       = vmax_q;
    assign vmin       = vmin_q;
    assign locked     = locked_q;
    assign no_signal  = no_signal_q;
endmodule

// File: tb/tb_tri_wave_meas.sv
// Bench for tri_wave_meas: table of triangle cycles feeding a scoreboard,
// plus hand-written idle, hysteresis, noise, timeout/recovery and async-reset sequences.
module tb_tri_wave_meas;
    localparam int DT_W    = 8;
    localparam int CNT_W   = 32;
    localparam int HYST    = 4;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_valid = 1'b0;
    logic [DT_W-1:0]  sample = '0;
    logic             meas_valid;
    logic [CNT_W-1:0] period, rise_time;
    logic [DT_W-1:0]  vmax, vmin;
    logic             locked, no_signal;

    tri_wave_meas #(.DT_W(DT_W), .CNT_W(CNT_W), .HYST(HYST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .meas_valid(meas_valid), .period(period), .rise_time(rise_time),
        .vmax(vmax), .vmin(vmin), .locked(locked), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    // One triangle cycle: lo, lo+1 .. lo+amp .. lo+1, one sample every div clocks.
    typedef struct {
        bit new_run;
        int lo;
        int amp;
        int div;
        bit report;
        int e_period;
        int e_rise;
        int e_vmax;
        int e_vmin;
        bit e_locked;
    } vec_t;

    typedef struct {
        int period;
        int rise;
        int vmax;
        int vmin;
        bit locked;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[10];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pulse = 0;
    bit   sb_en = 1'b1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int tri_val(input int lo, input int amp, input int i);
        return (i <= amp) ? lo + i : lo + 2 * amp - i;
    endfunction

    // Scoreboard consumer: every meas_valid pulse pops one expected record.
    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            n_pulse++;
            $display("meas #%0d period=%0d rise=%0d vmax=%0d vmin=%0d locked=%0b no_signal=%0b",
                     n_pulse, period, rise_time, vmax, vmin, locked, no_signal);
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_meas: got meas_valid=1, expected no pulse (t=%0t)", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("period", period, mon_e.period);
                    check("rise_time", rise_time, mon_e.rise);
                    check("vmax", vmax, mon_e.vmax);
                    check("vmin", vmin, mon_e.vmin);
                    check("locked", locked, mon_e.locked);
                    check("no_signal_meas", no_signal, 0);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put(input logic v, input int val);
        @(negedge clk);
        sample_valid = v;
        sample = DT_W'(val);
    endtask

    // Drives one cycle; the expected record is queued when the peak-trigger sample is driven.
    task automatic run_cycle(input vec_t v);
        exp_t e;
        for (int i = 0; i < 2 * v.amp; i++) begin
            for (int d = 0; d < v.div; d++) begin
                put(d == 0, tri_val(v.lo, v.amp, i));
                if (d == 0 && i == v.amp + HYST && v.report) begin
                    e.period = v.e_period;
                    e.rise   = v.e_rise;
                    e.vmax   = v.e_vmax;
                    e.vmin   = v.e_vmin;
                    e.locked = v.e_locked;
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int p0;
        int nz;
        int val;

        //            new lo amp div rep period rise vmax vmin lock
        vecs[0] = '{1'b1, 0, 100, 1, 1'b0,   0,   0,   0,  0, 1'b0};
        vecs[1] = '{1'b0, 0, 100, 1, 1'b1, 200, 100, 100,  0, 1'b0};
        vecs[2] = '{1'b0, 0, 100, 1, 1'b1, 200, 100, 100,  0, 1'b1};
        vecs[3] = '{1'b0, 0, 110, 1, 1'b1, 210, 110, 110,  0, 1'b1};
        vecs[4] = '{1'b0, 0, 160, 1, 1'b1, 270, 160, 160,  0, 1'b0};
        vecs[5] = '{1'b0, 0, 160, 1, 1'b1, 320, 160, 160,  0, 1'b0};
        vecs[6] = '{1'b0, 0, 160, 1, 1'b1, 320, 160, 160,  0, 1'b1};
        vecs[7] = '{1'b1, 20, 100, 4, 1'b0,   0,   0,   0,  0, 1'b0};
        vecs[8] = '{1'b0, 20, 100, 4, 1'b1, 800, 400, 120, 20, 1'b0};
        vecs[9] = '{1'b0, 20, 100, 4, 1'b1, 800, 400, 120, 20, 1'b1};

        // Reset and idle with no samples.
        do_reset();
        @(negedge clk);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_period", period, 0);
        check("rst_rise_time", rise_time, 0);
        check("rst_vmax", vmax, 0);
        check("rst_vmin", vmin, 0);
        check("rst_locked", locked, 0);
        check("rst_no_signal", no_signal, 1);
        repeat (TIMEOUT + 100) @(negedge clk);
        check("idle_no_signal", no_signal, 1);
        check("idle_locked", locked, 0);
        check("idle_pulses", n_pulse, 0);

        // Table-driven triangle cycles.
        for (int k = 0; k < 10; k++) begin
            if (vecs[k].new_run) do_reset();
            run_cycle(vecs[k]);
        end
        put(1'b0, 0);
        repeat (10) @(negedge clk);
        check("table_sb_drained", sb_q.size(), 0);
        check("table_no_signal", no_signal, 0);
        check("table_locked", locked, 1);

        // Swing below hysteresis: never leaves SEEK, so no events.
        do_reset();
        p0 = n_pulse;
        for (int i = 0; i < 600; i++) begin
            val = 50 + (((i % 4) == 3) ? 1 : (i % 4));
            put(1'b1, val);
        end
        put(1'b0, 0);
        check("hyst_pulses", n_pulse - p0, 0);
        check("hyst_no_signal", no_signal, 1);
        check("hyst_locked", locked, 0);

        // +/-2 LSB noise on a 0..200 triangle: one pulse per cycle after the second peak.
        do_reset();
        sb_en = 1'b0;
        p0 = n_pulse;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 400; i++) begin
                nz  = int'($urandom_range(4, 0)) - 2;
                val = tri_val(0, 200, i) + nz;
                if (val < 0) val = 0;
                put(1'b1, val);
            end
        end
        put(1'b0, 0);
        repeat (10) @(negedge clk);
        check("noise_pulses", n_pulse - p0, 3);
        check("noise_no_signal", no_signal, 0);
        sb_en = 1'b1;

        // Timeout while the stream is frozen mid-ramp, then recovery.
        do_reset();
        run_cycle(vecs[0]);
        run_cycle(vecs[1]);
        run_cycle(vecs[2]);
        for (int i = 0; i <= 50; i++) put(1'b1, i);
        put(1'b0, 50);
        p0 = n_pulse;
        repeat (500) @(negedge clk);
        check("pre_timeout_no_signal", no_signal, 0);
        check("pre_timeout_locked", locked, 1);
        repeat (600) @(negedge clk);
        check("timeout_no_signal", no_signal, 1);
        check("timeout_locked", locked, 0);
        check("timeout_period_held", period, 200);
        check("timeout_rise_held", rise_time, 100);
        check("timeout_vmax_held", vmax, 100);
        check("timeout_vmin_held", vmin, 0);
        check("timeout_pulses", n_pulse - p0, 0);
        for (int i = 0; i < 200; i++) begin
            put(1'b1, tri_val(0, 100, i));
            if (i == 104) check("recover_no_signal_before_peak", no_signal, 1);
            if (i == 105) check("recover_no_signal_after_peak", no_signal, 0);
        end
        check("recover_no_pulse_first_cycle", n_pulse - p0, 0);
        run_cycle(vecs[1]);
        run_cycle(vecs[2]);
        for (int i = 0; i < 20; i++) put(1'b1, i);

        // Asynchronous reset mid-run, checked before the next rising edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_meas_valid", meas_valid, 0);
        check("areset_period", period, 0);
        check("areset_rise_time", rise_time, 0);
        check("areset_vmax", vmax, 0);
        check("areset_vmin", vmin, 0);
        check("areset_locked", locked, 0);
        check("areset_no_signal", no_signal, 1);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("final_sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tri_wave_meas.md
Name: tri_wave_meas

Overview:
- Receive side of the triangle-wave test path: analyses an 8-bit sample stream, typically ADC samples of the triangle DDS output looped back through the scope front end.
- Detects peaks and troughs using hysteresis.
- Measures period, rise time and peak/trough levels in clk cycles.
- Flags lock (stable period) and loss of signal.
- Sits between the ADC capture logic and the measurement/display logic.

Parameters:
- DT_W, 8: sample width.
- CNT_W, 32: width of the cycle counters and of period/rise_time.
- HYST, 4: hysteresis in LSBs needed to declare a turning point.
- TIMEOUT, 50_000_000: clk cycles without a turning point before no_signal is declared.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- sample_valid  in  1  sample qualifier; the sample is accepted on the rising edge while high.
- sample  in  DT_W  unsigned sample value.
- meas_valid  out  1  one-cycle pulse; the measurement outputs are updated in the same cycle.
- period  out  CNT_W  clk cycles between the last two peak events.
- rise_time  out  CNT_W  clk cycles from the last trough event to the current peak event.
- vmax  out  DT_W  peak value of the last completed cycle.
- vmin  out  DT_W  trough value of the last completed cycle.
- locked  out  1  period stable.
- no_signal  out  1  timeout active.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. All state is clocked on the rising edge of clk.
- Reset values:
  - meas_valid, period, rise_time, vmax, vmin, locked = 0.
  - no_signal = 1.
  - FSM = SEEK; cur_max = cur_min = 0; all counters = 0; have_peak = have_trough = 0.
- Reset asserted mid-operation: all of the above is restored immediately, with no measurement pulse.
- FSM states: SEEK, RISE, FALL. Registers updated only on accepted samples: cur_max, cur_min, first flag. Comparisons are done in DT_W+1 bits, with no underflow or overflow.
- SEEK:
  - First accepted sample sets cur_max = cur_min = sample.
  - Subsequent samples:
    - sample >= cur_min+HYST: go to RISE, cur_max = sample.
    - sample+HYST <= cur_max: go to FALL, cur_min = sample.
    - Otherwise, update cur_max/cur_min as the running max/min.
  - No events are generated in SEEK.
- RISE:
  - cur_max tracks the running maximum.
  - When sample+HYST <= cur_max, this is a PEAK EVENT: go to FALL, cur_min = sample.
- FALL:
  - cur_min tracks the running minimum.
  - When sample >= cur_min+HYST, this is a TROUGH EVENT: go to RISE, cur_max = sample.
  - The trough value (old cur_min) is latched into tr_val.
- Counters:
  - cnt_pk and cnt_tr increment every clk cycle (not per sample), saturating at 2^CNT_W-1.
  - cnt_pk clears to 0 on the edge of a peak event; cnt_tr clears on the edge of a trough event.
  - cnt_idle clears on any event and saturates at TIMEOUT.
- Peak event outputs:
  - If have_peak and have_trough, then on the same edge: period = cnt_pk+1, rise_time = cnt_tr+1, vmax = old cur_max, vmin = tr_val, meas_valid = 1 for exactly one cycle.
  - A peak event sets have_peak; a trough event sets have_trough.
  - Latency: meas_valid is high in the cycle after the triggering sample is presented.
- Lock:
  - On each meas_valid with a previous period available (prev_period != 0), locked = (|period - prev_period| <= prev_period>>3); prev_period is then updated.
  - The first measurement leaves locked = 0.
- Timeout:
  - When cnt_idle reaches TIMEOUT: no_signal = 1, locked = 0, FSM goes to SEEK (first flag re-armed), have_peak = have_trough = 0, prev_period = 0.
  - period, rise_time, vmax and vmin hold their last values.
- no_signal clears on the edge of the next peak or trough event.
- Gaps in sample_valid: FSM and extrema hold; counters keep counting clk cycles.
- Saturated counter at an event: the saturated value+1 is not reported; the saturated value itself is reported.
- Constant input, or swing < HYST: FSM stays in SEEK, no meas_valid, timeout after TIMEOUT cycles.
- Single-cycle events only. A peak and a trough cannot occur on the same sample.

Test Plan:
- Reset/idle: hold rst_n=0 then release with sample_valid=0 -> all outputs 0, no_signal=1. After TIMEOUT cycles, no_signal is still 1 and there are no pulses.
- Clean triangle: sample_valid=1 every cycle, ramp 0->100->0 step 1, repeated -> first meas_valid after the second peak event. Then period=200, rise_time=100, vmax=100, vmin=0. locked=1 from the second measurement; no_signal=0.
- Decimated input: same ramp with sample_valid high every 4th cycle -> period=800, rise_time=400, locked=1.
- Hysteresis: triangle 50..52 (swing 2 < HYST=4) -> no meas_valid, stays in SEEK. Add +/-2 LSB noise on a 0..200 triangle -> exactly one meas_valid per cycle.
- Lock loss: switch period 200->260 mid-run -> first measurement at 260 gives locked=0, next gives locked=1. A 210 period after a 200 period (diff 10 <= 25) keeps locked=1.
- Timeout and recovery (TIMEOUT=1000 in bench): freeze the sample mid-ramp -> no_signal=1 and locked=0 after 1000 cycles, outputs held. Restart the triangle -> no_signal clears at the first event; meas_valid resumes after one full cycle. Asserting rst_n=0 mid-run clears everything asynchronously.
